// File: rtl/spram_banked_ctrl.sv
// Banked single-port SRAM controller: word-interleaved behavioural banks, byte-masked writes,
// 2-cycle read pipeline into a 2-deep in-order response FIFO, and a hardware init sweep.
module spram_banked_ctrl #(
    parameter int MEM_WIDTH  = 32,
    parameter int MEM_DEPTH  = 4096,
    parameter int NUM_BANKS  = 4,
    parameter int BYTE_WIDTH = 8,
    parameter logic [MEM_WIDTH-1:0] INIT_VALUE = {{(MEM_WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic                              req_we,
    input  logic [$clog2(MEM_DEPTH)-1:0]      req_addr,
    input  logic [MEM_WIDTH-1:0]              req_wdata,
    input  logic [MEM_WIDTH/BYTE_WIDTH-1:0]   req_wmask,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [MEM_WIDTH-1:0]              rsp_rdata,
    input  logic                              init_req,
    output logic                              init_done
);
    localparam int ADDR_W = $clog2(MEM_DEPTH);
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int ROWS   = MEM_DEPTH / NUM_BANKS;
    localparam int ROW_W  = $clog2(ROWS);
    localparam int LANES  = MEM_WIDTH / BYTE_WIDTH;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    typedef enum logic {ST_INIT = 1'b0, ST_ACTIVE = 1'b1} state_t;

    state_t                 state_r, state_s;
    logic [ROW_W-1:0]       row_r;
    logic                   init_done_r;
    logic                   pending_r;
    logic                   start_init_s;
    logic                   pipe_valid_r;
    logic [MEM_WIDTH-1:0]   pipe_data_r;
    logic [MEM_WIDTH-1:0]   fifo_mem_r [2];
    logic                   wr_ptr_r, rd_ptr_r;
    logic [1:0]             fifo_cnt_r;
    logic [1:0]             cnt_s;
    logic                   accept_s, wr_acc_s, rd_acc_s, push_s, pop_s;
    logic [MEM_WIDTH-1:0]   bit_mask_s;
    logic [MEM_WIDTH-1:0]   bank_rd_s [NUM_BANKS];
    logic [BANK_W-1:0]      bank_s;
    logic [ROW_W-1:0]       row_s;

    assign bank_s    = req_addr[BANK_W-1:0];
    assign row_s     = req_addr[ADDR_W-1:BANK_W];
    assign rsp_valid = (fifo_cnt_r != 2'd0);
    assign rsp_rdata = fifo_mem_r[rd_ptr_r];
    assign init_done = init_done_r;

    // Request/response handshake decode; cnt counts reads in the pipe plus buffered responses.
    always_comb begin
        cnt_s     = fifo_cnt_r + {1'b0, pipe_valid_r};
        req_ready = (state_r == ST_ACTIVE) && init_done_r && !pending_r && (cnt_s < 2'd2);
        accept_s  = req_valid && req_ready;
        wr_acc_s  = accept_s && req_we;
        rd_acc_s  = accept_s && !req_we;
        push_s    = pipe_valid_r;
        pop_s     = rsp_valid && rsp_ready;
        bit_mask_s = '0;
        for (int l = 0; l < LANES; l++) begin
            bit_mask_s[l*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{req_wmask[l]}};
        end
    end

    // Next-state logic; a pending re-init only starts once every read has drained.
    always_comb begin
        state_s      = state_r;
        start_init_s = 1'b0;
        case (state_r)
            ST_INIT: begin
                if (row_r == LAST_ROW) state_s = ST_ACTIVE;
                else                   state_s = ST_INIT;
            end
            ST_ACTIVE: begin
                if (pending_r && (cnt_s == 2'd0)) begin
                    start_init_s = 1'b1;
                    state_s      = ST_INIT;
                end else begin
                    state_s = ST_ACTIVE;
                end
            end
            default: state_s = ST_INIT;
        endcase
    end

    // State register, sweep row counter, init_done and pending-init flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_INIT;
            row_r       <= '0;
            init_done_r <= 1'b0;
            pending_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            case (state_r)
                ST_INIT: begin
                    if (row_r == LAST_ROW) init_done_r <= 1'b1;
                    else                   row_r <= row_r + ROW_W'(1);
                end
                ST_ACTIVE: begin
                    if (start_init_s) begin
                        row_r       <= '0;
                        init_done_r <= 1'b0;
                        pending_r   <= 1'b0;
                    end else if (init_req) begin
                        pending_r <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Read pipeline stage feeding the 2-entry in-order response FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_valid_r  <= 1'b0;
            pipe_data_r   <= '0;
            fifo_mem_r[0] <= '0;
            fifo_mem_r[1] <= '0;
            wr_ptr_r      <= 1'b0;
            rd_ptr_r      <= 1'b0;
            fifo_cnt_r    <= 2'd0;
        end else begin
            pipe_valid_r <= rd_acc_s;
            if (rd_acc_s) pipe_data_r <= bank_rd_s[bank_s];
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= pipe_data_r;
                wr_ptr_r             <= ~wr_ptr_r;
            end
            if (pop_s) rd_ptr_r <= ~rd_ptr_r;
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + 2'd1;
                2'b01:   fifo_cnt_r <= fifo_cnt_r - 2'd1;
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [MEM_WIDTH-1:0] mem [ROWS];

        assign bank_rd_s[b] = mem[row_s];

        // Bank storage: sweep writes every bank in parallel; contents survive reset.
        always_ff @(posedge clk) begin
            if (rst_n) begin
                if (state_r == ST_INIT) begin
                    mem[row_r] <= INIT_VALUE;
                end else if (wr_acc_s && (bank_s == BANK_W'(b))) begin
                    mem[row_s] <= (bank_rd_s[b] & ~bit_mask_s) | (req_wdata & bit_mask_s);
                end
            end
        end
    end
endmodule

// File: tb/tb_spram_banked_ctrl.sv
// Self-checking bench for spram_banked_ctrl (MEM_DEPTH=64, 4 banks): a transaction-level model
// is compared against the DUT every cycle, plus directed literal checks.
module tb_spram_banked_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [5:0]  req_addr = 6'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [3:0]  req_wmask = 4'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        init_req = 1'b0;
    logic        init_done;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    spram_banked_ctrl #(
        .MEM_WIDTH(32), .MEM_DEPTH(64), .NUM_BANKS(4), .BYTE_WIDTH(8), .INIT_VALUE(32'd1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .init_req(init_req), .init_done(init_done)
    );

    always #5 clk = ~clk;

    // Model: memory image, outstanding-read queue with the cycle each becomes visible.
    logic [31:0] m_mem [64];
    logic [31:0] m_q_data [$];
    int          m_q_time [$];
    int          m_cyc = 0;
    int          m_init_left = 16;
    bit          m_init_done = 1'b0;
    bit          m_pending = 1'b0;
    bit          m_ready_pre, m_pop_pre, m_start;

    function automatic bit exp_ready();
        return m_init_done && !m_pending && (m_q_data.size() < 2);
    endfunction

    function automatic bit exp_valid();
        return (m_q_data.size() > 0) && (m_q_time[0] <= m_cyc);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        m_ready_pre = exp_ready();
        m_pop_pre   = exp_valid() && rsp_ready;
        m_start     = m_init_done && m_pending && (m_q_data.size() == 0);
        if (!rst_n) begin
            m_q_data.delete();
            m_q_time.delete();
            m_init_left = 16;
            m_init_done = 1'b0;
            m_pending   = 1'b0;
        end else if (m_init_left > 0) begin
            m_init_left--;
            if (m_init_left == 0) begin
                for (int i = 0; i < 64; i++) m_mem[i] = 32'd1;
                m_init_done = 1'b1;
            end
        end else begin
            if (m_pop_pre) begin
                void'(m_q_data.pop_front());
                void'(m_q_time.pop_front());
            end
            if (req_valid && m_ready_pre) begin
                if (req_we) begin
                    for (int l = 0; l < 4; l++)
                        if (req_wmask[l]) m_mem[req_addr][l*8 +: 8] = req_wdata[l*8 +: 8];
                end else begin
                    m_q_data.push_back(m_mem[req_addr]);
                    m_q_time.push_back(m_cyc + 2);
                end
            end
            if (m_start) begin
                m_init_done = 1'b0;
                m_init_left = 16;
                m_pending   = 1'b0;
            end else if (init_req) begin
                m_pending = 1'b1;
            end
        end
        m_cyc++;
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_req_ready", {31'd0, req_ready}, {31'd0, exp_ready()});
            chk("m_rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_valid()});
            chk("m_init_done", {31'd0, init_done}, {31'd0, m_init_done});
            if (exp_valid()) chk("m_rsp_rdata", rsp_rdata, m_q_data[0]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk(name, {31'd0, req_ready}, 32'd1);
    endtask

    task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] m);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; req_wmask = m;
        wait_ready("wr_accept_timeout");
        tick();
        req_valid = 1'b0; req_we = 1'b0;
    endtask

    task automatic do_read(input logic [5:0] a, output logic [31:0] d, output int lat);
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = a;
        wait_ready("rd_accept_timeout");
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 50) begin
            tick();
            lat++;
        end
        d = rsp_rdata;
        tick();
    endtask

    task automatic wait_sweep(input string name);
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 15) begin
                chk({name, "_done_at15"}, {31'd0, init_done}, 32'd0);
                chk({name, "_ready_at15"}, {31'd0, req_ready}, 32'd0);
            end
            if (i == 16) chk({name, "_done_at16"}, {31'd0, init_done}, 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int lat;
        logic [5:0] rd_addrs [3];
        rd_addrs[0] = 6'd0; rd_addrs[1] = 6'd37; rd_addrs[2] = 6'd63;

        // Reset state
        tick();
        cmp_en = 1'b1;
        tick(); tick();
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        rst_n = 1'b1;
        wait_sweep("init1");

        for (int i = 0; i < 3; i++) begin
            do_read(rd_addrs[i], d, lat);
            chk("init_value_read", d, 32'h0000_0001);
        end

        // Write then read-after-write
        do_write(6'd5, 32'hDEAD_BEEF, 4'b1111);
        do_read(6'd5, d, lat);
        chk("raw_data", d, 32'hDEAD_BEEF);
        chk("raw_latency", lat, 32'd2);

        do_write(6'd5, 32'h1122_3344, 4'b0101);
        do_read(6'd5, d, lat);
        chk("mask_0101", d, 32'hDE22_BE44);
        do_write(6'd5, 32'hFFFF_FFFF, 4'b0000);
        do_read(6'd5, d, lat);
        chk("mask_0000", d, 32'hDE22_BE44);

        // Back-pressure: two reads accepted, third stalls until a response drains
        do_write(6'd1, 32'hA1A1_A1A1, 4'b1111);
        do_write(6'd2, 32'hB2B2_B2B2, 4'b1111);
        do_write(6'd3, 32'hC3C3_C3C3, 4'b1111);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 6'd1;
        chk("bp_ready_rd1", {31'd0, req_ready}, 32'd1);
        tick();
        req_addr = 6'd2;
        chk("bp_ready_rd2", {31'd0, req_ready}, 32'd1);
        tick();
        req_addr = 6'd3;
        tick(); tick();
        chk("bp_ready_full", {31'd0, req_ready}, 32'd0);
        chk("bp_head1", rsp_rdata, 32'hA1A1_A1A1);
        rsp_ready = 1'b1;
        tick();
        chk("bp_head2", rsp_rdata, 32'hB2B2_B2B2);
        chk("bp_ready_after_pop", {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        tick();
        chk("bp_rsp3_valid", {31'd0, rsp_valid}, 32'd1);
        chk("bp_rsp3_data", rsp_rdata, 32'hC3C3_C3C3);
        tick();

        // init_req with one read outstanding
        req_valid = 1'b1; req_addr = 6'd5;
        wait_ready("ir_accept_timeout");
        tick();
        req_valid = 1'b0; init_req = 1'b1;
        tick();
        init_req = 1'b0;
        chk("ir_ready_drop", {31'd0, req_ready}, 32'd0);
        chk("ir_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("ir_rsp_data", rsp_rdata, 32'hDE22_BE44);
        chk("ir_done_still", {31'd0, init_done}, 32'd1);
        tick();
        tick();
        chk("ir_done_fall", {31'd0, init_done}, 32'd0);
        wait_sweep("init2");
        do_read(6'd5, d, lat);
        chk("ir_reinit_value", d, 32'h0000_0001);

        // Reset with two buffered responses
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 6'd0;
        tick();
        req_addr = 6'd1;
        tick();
        req_valid = 1'b0;
        tick();
        chk("rr_buffered", {31'd0, rsp_valid}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rr_rsp_rdata", rsp_rdata, 32'd0);
        chk("rr_init_done", {31'd0, init_done}, 32'd0);
        wait_sweep("init3");
        do_read(6'd63, d, lat);
        chk("rr_last_addr", d, 32'h0000_0001);

        tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
